// File: rtl/sspm_pkg.sv
// sspm_pkg: shared types and limits for the shared-SPM arbiter.
// Revision 1.0
`default_nettype none

package sspm_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } sspm_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int NCORES_MIN = 2;
  localparam int NCORES_MAX = 8;

endpackage

`default_nettype wire

// File: rtl/sspm_rr_pick.sv
// sspm_rr_pick: combinational rotate-priority one-hot picker (req, ptr -> grant).
// Revision 1.0
`default_nettype none

module sspm_rr_pick #(
  parameter int NCORES = 4,
  parameter int PTR_W  = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NCORES-1:0] grant
);

  logic found;
  int   idx;

  // First requester at or after ptr, wrapping modulo NCORES.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NCORES; i++) begin
      idx = (int'(ptr) + i) % NCORES;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sspm_arbiter.sv
// sspm_arbiter: one-access-per-cycle arbiter for a shared single-port SPM; round-robin by
// default, fixed TDM slots when SSPM_ARB_TDM_EN is defined. Revision 1.0
`default_nettype none

module sspm_arbiter
  import sspm_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        req_i,
  input  logic [NCORES-1:0]        we_i,
  input  logic [NCORES*ADDR_W-1:0] addr_i,
  input  logic [NCORES*DATA_W-1:0] wdata_i,
  output logic [NCORES-1:0]        select_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i
);

  localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  sspm_state_t       state;
  logic [NCORES-1:0] pick_req;
  logic [NCORES-1:0] grant;
  logic [PTR_W-1:0]  pick_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;
  logic              any_grant;

`ifdef SSPM_ARB_TDM_EN
  // The slot counter takes the pointer's place; only the slot owner may be picked.
  logic [PTR_W-1:0] slot;
  assign pick_req = req_i & (NCORES'(1) << slot);
  assign pick_ptr = slot;
`else
  logic [PTR_W-1:0] ptr;
  assign pick_req = req_i;
  assign pick_ptr = ptr;
`endif

  sspm_rr_pick #(
    .NCORES (NCORES),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (grant)
  );

  assign any_grant = |grant;

  always_comb begin
    grant_idx = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      if (grant[k]) begin
        grant_idx = PTR_W'(k);
        win_addr  = addr_i[k*ADDR_W +: ADDR_W];
        win_wdata = wdata_i[k*DATA_W +: DATA_W];
        win_we    = we_i[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      select_o    <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
`ifdef SSPM_ARB_TDM_EN
      slot        <= '0;
`else
      ptr         <= '0;
`endif
    end else begin
      state       <= any_grant ? ACCESS : IDLE;
      select_o    <= grant;
      mem_we_o    <= any_grant & win_we;
      mem_addr_o  <= win_addr;
      mem_wdata_o <= win_wdata;
`ifdef SSPM_ARB_TDM_EN
      slot        <= (slot == PTR_W'(NCORES-1)) ? '0 : slot + PTR_W'(1);
`else
      if (any_grant) begin
        ptr <= (grant_idx == PTR_W'(NCORES-1)) ? '0 : grant_idx + PTR_W'(1);
      end
`endif
    end
  end

  // ACCESS holds exactly when a grant is registered, so it doubles as the SRAM enable.
  assign mem_en_o = (state == ACCESS);
  assign rdata_o  = mem_rdata_i;

endmodule

`default_nettype wire
